// File: rtl/ro_freq_compare.sv
// Counts rising edges of two asynchronous RO taps over a fixed gate window and emits a PUF bit.
// Define RO_COMPARE_CONTINUOUS_EN for free-running back-to-back measurements.
module ro_freq_compare #(
    parameter int unsigned GATE_CYCLES = 1200000,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             ICE_CLK,
    input  logic             rst,
    input  logic             start,
    input  logic             ro_a,
    input  logic             ro_b,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count_a,
    output logic [CNT_W-1:0] count_b,
    output logic             resp,
    output logic             ovf
);

    localparam int unsigned GW = $clog2(GATE_CYCLES + 1);
    localparam int unsigned SW = $clog2(SYNC_STAGES + 1);
    localparam int unsigned TW = (GW > SW) ? GW : SW;

    typedef enum logic [1:0] {StIdle, StSettle, StGate, StDone} state_e;

    state_e state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;

    logic [SYNC_STAGES-1:0] sync_a_q, sync_b_q;
    logic                   dly_a_q, dly_b_q;
    logic                   edge_a, edge_b;

    logic [CNT_W-1:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
    logic             sat_a_q, sat_a_d, sat_b_q, sat_b_d;
    logic             clear, load;

    logic [CNT_W-1:0] count_a_q, count_b_q;
    logic             resp_q, ovf_q;

    assign edge_a = sync_a_q[SYNC_STAGES-1] & ~dly_a_q;
    assign edge_b = sync_b_q[SYNC_STAGES-1] & ~dly_b_q;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        clear   = 1'b0;
        load    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StSettle;
                    timer_d = '0;
                    clear   = 1'b1;
                end
            end
            StSettle: begin
                // Hold long enough for edges already in the sync pipeline to drain.
                if (timer_q == TW'(SYNC_STAGES)) begin
                    state_d = StGate;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StGate: begin
                if (timer_q == TW'(GATE_CYCLES - 1)) begin
                    state_d = StDone;
                    load    = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StDone: begin
`ifdef RO_COMPARE_CONTINUOUS_EN
                state_d = StSettle;
                timer_d = '0;
                clear   = 1'b1;
`else
                state_d = StIdle;
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    // Saturating edge counters; next-values include an edge on the final gate cycle.
    always_comb begin
        cnt_a_d = cnt_a_q;
        cnt_b_d = cnt_b_q;
        sat_a_d = sat_a_q;
        sat_b_d = sat_b_q;
        if (state_q == StGate && edge_a) begin
            if (&cnt_a_q) sat_a_d = 1'b1;
            else          cnt_a_d = cnt_a_q + 1'b1;
        end
        if (state_q == StGate && edge_b) begin
            if (&cnt_b_q) sat_b_d = 1'b1;
            else          cnt_b_d = cnt_b_q + 1'b1;
        end
    end

    always_ff @(posedge ICE_CLK) begin
        if (rst) begin
            state_q   <= StIdle;
            timer_q   <= '0;
            sync_a_q  <= '0;
            sync_b_q  <= '0;
            dly_a_q   <= 1'b0;
            dly_b_q   <= 1'b0;
            cnt_a_q   <= '0;
            cnt_b_q   <= '0;
            sat_a_q   <= 1'b0;
            sat_b_q   <= 1'b0;
            count_a_q <= '0;
            count_b_q <= '0;
            resp_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            sync_a_q <= {sync_a_q[SYNC_STAGES-2:0], ro_a};
            sync_b_q <= {sync_b_q[SYNC_STAGES-2:0], ro_b};
            dly_a_q  <= sync_a_q[SYNC_STAGES-1];
            dly_b_q  <= sync_b_q[SYNC_STAGES-1];
            if (clear) begin
                cnt_a_q <= '0;
                cnt_b_q <= '0;
                sat_a_q <= 1'b0;
                sat_b_q <= 1'b0;
            end else begin
                cnt_a_q <= cnt_a_d;
                cnt_b_q <= cnt_b_d;
                sat_a_q <= sat_a_d;
                sat_b_q <= sat_b_d;
            end
            if (load) begin
                count_a_q <= cnt_a_d;
                count_b_q <= cnt_b_d;
                resp_q    <= (cnt_a_d > cnt_b_d);
                ovf_q     <= sat_a_d | sat_b_d;
            end
        end
    end

    assign busy    = (state_q == StSettle) || (state_q == StGate);
    assign done    = (state_q == StDone);
    assign count_a = count_a_q;
    assign count_b = count_b_q;
    assign resp    = resp_q;
    assign ovf     = ovf_q;

endmodule
